// File: rtl/apb2axi_pkg.sv
// Shared types for the APB-to-AXI read-data path.
// TAG_W / TAG_NUM : AXI ID width and number of distinct tags.
// RDF_DEPTH       : default beat capacity of the read-data buffer.
// rdf_entry_t     : one stored R beat (tag, data, last, resp).
// rdf_state_e     : read-data buffer control states.
package apb2axi_pkg;

  localparam int unsigned TAG_W     = 3;
  localparam int unsigned TAG_NUM   = 1 << TAG_W;
  localparam int unsigned RDF_DEPTH = 32;

  typedef logic [$clog2(RDF_DEPTH)-1:0] rdf_slot_idx_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             last;
    logic [1:0]       resp;
  } rdf_entry_t;

  typedef enum logic {
    StIdle,
    StFlush
  } rdf_state_e;

endpackage

// File: rtl/apb2axi_rdf_freelist.sv
// Free-slot index FIFO for the read-data buffer.
// Reset fills it with indices 0..DEPTH-1 in order.
// clk, rst_n            : clock, async active-low reset.
// alloc / alloc_idx     : take the index at the read pointer.
// free / free_idx       : return an index at the write pointer.
// count                 : number of indices currently held.
module apb2axi_rdf_freelist #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IDX_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             free,
  input  logic [IDX_W-1:0] free_idx,
  output logic [CNT_W-1:0] count
);

  logic [IDX_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  assign alloc_idx = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Starts full, so wr_ptr equals rd_ptr; both wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= IDX_W'(i);
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= CNT_W'(DEPTH);
    end else begin
      if (alloc) rd_ptr_q <= rd_ptr_q + IDX_W'(1);
      if (free) begin
        mem_q[wr_ptr_q] <= free_idx;
        wr_ptr_q        <= wr_ptr_q + IDX_W'(1);
      end
      unique case ({alloc, free})
        2'b10:   count_q <= count_q - CNT_W'(1);
        2'b01:   count_q <= count_q + CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    alloc |-> count_q != '0);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (free && !alloc) |-> count_q != CNT_W'(DEPTH));

endmodule

// File: rtl/apb2axi_rdf_buffer.sv
// Shared read-data buffer: R beats stored in a common slot pool, linked per tag
// so interleaved/out-of-order IDs can be drained one tag at a time.
// aclk, aresetn           : clock, async active-low reset.
// push_vld/payload/rdy    : beat input from the response collector.
// pop_req/tag/rdy         : request one beat of a tag (rdy combinational).
// pop_vld/payload         : registered one-cycle pop result.
// tag_cnt, tag_done       : per-tag stored-beat counts and last-stored flags.
// free_cnt                : free slots.
// flush_req/tag/busy      : discard every beat of a tag, one slot per cycle.
module apb2axi_rdf_buffer
  import apb2axi_pkg::*;
#(
  parameter int unsigned DEPTH = RDF_DEPTH,
  parameter int unsigned IDX_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     push_vld,
  input  rdf_entry_t               push_payload,
  output logic                     push_rdy,
  input  logic                     pop_req,
  input  logic [TAG_W-1:0]         pop_tag,
  output logic                     pop_rdy,
  output logic                     pop_vld,
  output rdf_entry_t               pop_payload,
  output logic [TAG_NUM*CNT_W-1:0] tag_cnt,
  output logic [TAG_NUM-1:0]       tag_done,
  output logic [CNT_W-1:0]         free_cnt,
  input  logic                     flush_req,
  input  logic [TAG_W-1:0]         flush_tag,
  output logic                     flush_busy
);

  rdf_state_e       state_q, state_d;
  logic [TAG_W-1:0] flush_tag_q, flush_tag_d;
  logic [IDX_W-1:0] head_q [TAG_NUM];
  logic [IDX_W-1:0] head_d [TAG_NUM];
  logic [IDX_W-1:0] tail_q [TAG_NUM];
  logic [IDX_W-1:0] tail_d [TAG_NUM];
  logic [CNT_W-1:0] cnt_q  [TAG_NUM];
  logic [CNT_W-1:0] cnt_d  [TAG_NUM];
  logic [TAG_NUM-1:0] done_q, done_d;
  logic             pop_vld_q;
  rdf_entry_t       pop_payload_q;

  rdf_entry_t       data_ram [DEPTH];
  logic [IDX_W-1:0] next_ram [DEPTH];

  logic [IDX_W-1:0] alloc_idx, rm_idx;
  logic [TAG_W-1:0] push_tag, rm_tag;
  logic             idle, push_hit, pop_hit, flush_hit, rm_hit, bypass, link;

  assign idle       = (state_q == StIdle);
  assign push_tag   = push_payload.tag;
  // Gated by reset so no beat is offered while the buffer is held in reset.
  assign push_rdy   = aresetn && idle && (free_cnt != '0);
  assign pop_rdy    = idle && (cnt_q[pop_tag] != '0);
  assign push_hit   = push_vld && push_rdy;
  assign pop_hit    = pop_req && pop_rdy;
  assign flush_hit  = !idle && (cnt_q[flush_tag_q] != '0);
  // Pop (IDLE) and flush (FLUSH) never coincide, so they share one removal path.
  assign rm_hit     = pop_hit || flush_hit;
  assign rm_tag     = idle ? pop_tag : flush_tag_q;
  assign rm_idx     = head_q[rm_tag];
  // Same-tag pop of the only beat plus push: new slot becomes head and tail.
  assign bypass     = push_hit && pop_hit && (push_tag == pop_tag) &&
                      (cnt_q[push_tag] == CNT_W'(1));
  assign link       = push_hit && (cnt_q[push_tag] != '0) && !bypass;

  assign pop_vld    = pop_vld_q;
  assign pop_payload = pop_payload_q;
  assign tag_done   = done_q;
  assign flush_busy = !idle;

  always_comb begin
    tag_cnt = '0;
    for (int t = 0; t < TAG_NUM; t++) tag_cnt[t*CNT_W +: CNT_W] = cnt_q[t];
  end

  apb2axi_rdf_freelist #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_freelist (
    .clk       (aclk),
    .rst_n     (aresetn),
    .alloc     (push_hit),
    .alloc_idx (alloc_idx),
    .free      (rm_hit),
    .free_idx  (rm_idx),
    .count     (free_cnt)
  );

  // Per-tag list bookkeeping; removal applied before insertion so a pushed
  // last beat wins over a popped one.
  always_comb begin
    done_d = done_q;
    for (int t = 0; t < TAG_NUM; t++) begin
      head_d[t] = head_q[t];
      tail_d[t] = tail_q[t];
      cnt_d[t]  = cnt_q[t];
      if (rm_hit && (rm_tag == TAG_W'(t))) begin
        head_d[t] = next_ram[rm_idx];
        cnt_d[t]  = cnt_d[t] - CNT_W'(1);
        if ((pop_hit && data_ram[rm_idx].last) ||
            (flush_hit && (cnt_q[t] == CNT_W'(1)))) begin
          done_d[t] = 1'b0;
        end
      end
      if (push_hit && (push_tag == TAG_W'(t))) begin
        cnt_d[t]  = cnt_d[t] + CNT_W'(1);
        tail_d[t] = alloc_idx;
        if ((cnt_q[t] == '0) || bypass) head_d[t] = alloc_idx;
        if (push_payload.last) done_d[t] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_tag_d = flush_tag_q;
    unique case (state_q)
      StIdle: begin
        if (flush_req) begin
          state_d     = StFlush;
          flush_tag_d = flush_tag;
        end
      end
      StFlush: begin
        // Empty tag leaves at once; otherwise leave as the final slot is freed.
        if (cnt_q[flush_tag_q] <= CNT_W'(1)) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      flush_tag_q   <= '0;
      done_q        <= '0;
      pop_vld_q     <= 1'b0;
      pop_payload_q <= '0;
      for (int t = 0; t < TAG_NUM; t++) begin
        head_q[t] <= '0;
        tail_q[t] <= '0;
        cnt_q[t]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      flush_tag_q <= flush_tag_d;
      done_q      <= done_d;
      pop_vld_q   <= pop_hit;
      if (pop_hit) pop_payload_q <= data_ram[rm_idx];
      for (int t = 0; t < TAG_NUM; t++) begin
        head_q[t] <= head_d[t];
        tail_q[t] <= tail_d[t];
        cnt_q[t]  <= cnt_d[t];
      end
    end
  end

  // Storage arrays carry no reset; only list pointers/counts define validity.
  always_ff @(posedge aclk) begin
    if (push_hit) data_ram[alloc_idx] <= push_payload;
    if (link) next_ram[tail_q[push_tag]] <= alloc_idx;
  end

endmodule

// File: doc/apb2axi_rdf_buffer.md
Name: apb2axi_rdf_buffer

Overview:
- Single-clock (ACLK) shared read-data buffer directly downstream of the response collector's RDF push port.
- Stores incoming R beats (rdf_entry_t) in a shared pool of DEPTH slots, organised as per-tag linked lists, so reads returned with interleaved or out-of-order RIDs can be drained one tag at a time.
- Provides per-tag pop by tag, per-tag beat counts, per-tag done flags, and a per-tag flush that returns slots to the free pool.

Parameters:
- DEPTH, 32, total beat slots shared by all tags (power of two, ≥ TAG_NUM).
- IDX_W, $clog2(DEPTH), slot index width.
- CNT_W, $clog2(DEPTH+1), width of free and per-tag counters.

Ports:
- aclk  in  1  ACLK.
- aresetn  in  1  asynchronous active-low reset.
- push_vld  in  1  beat valid from the collector.
- push_payload  in  rdf_entry_t  tag/data/last/resp.
- push_rdy  out  1  slot available; independent of push tag.
- pop_req  in  1  pop-one-beat request.
- pop_tag  in  TAG_W  tag to pop.
- pop_rdy  out  1  combinational: selected tag non-empty and FSM in IDLE.
- pop_vld  out  1  registered pop data valid.
- pop_payload  out  rdf_entry_t  popped beat.
- tag_cnt  out  TAG_NUM*CNT_W  flat per-tag stored-beat counts; tag t at [t*CNT_W +: CNT_W].
- tag_done  out  TAG_NUM  last beat of tag stored and not yet popped or flushed.
- free_cnt  out  CNT_W  free slots.
- flush_req  in  1  flush request.
- flush_tag  in  TAG_W  tag to flush.
- flush_busy  out  1  flush in progress.

Behaviour:
- Reset (async, aresetn=0):
  - push_rdy=0, pop_vld=0, pop_payload='0, tag_cnt=0, tag_done=0, flush_busy=0, free_cnt=DEPTH.
  - Free-list FIFO holds indices 0..DEPTH-1 in order; all head/tail pointers and list-valid bits cleared.
  - Data RAM is not reset.
- push_rdy = (free_cnt != 0) && state==IDLE.
- Push accepted when push_vld && push_rdy:
  - Pop a slot from the free list and write the payload.
  - If the tag list is empty: head=tail=slot. Otherwise next[tail]=slot and tail=slot.
  - tag_cnt[tag]++. If last=1, set tag_done[tag].
  - Push with push_rdy=0 is dropped; upstream must not assert valid without ready.
- Pop accepted when pop_req && pop_rdy:
  - Next cycle: pop_vld=1 and pop_payload=data[head]; single-cycle pulse, no output backpressure.
  - Head slot returns to the free list.
  - head=next[head]. If cnt was 1, the list becomes empty.
  - tag_cnt--. If the popped beat has last=1, clear tag_done[tag].
  - pop_req when pop_rdy=0 is ignored and produces no pop_vld.
- Simultaneous push and pop:
  - Both are allowed in the same cycle; free_cnt is unchanged.
  - Same tag with cnt==1: the pop empties the old head and the push makes the new slot both head and tail (next-pointer bypass). The list is never left with a stale head.
  - Same tag with cnt>1: normal independent updates.
  - Free list performs one read and one write in the cycle; write pointer and read pointer wrap modulo DEPTH.
- FSM states:
  - IDLE: flush_req → FLUSH; latch flush_tag; flush_busy=1 from the next cycle.
  - FLUSH: one slot per cycle moves from head to the free list and tag_cnt decrements. When cnt reaches 1 and that slot is freed: clear tag_done[tag], mark the list empty, return to IDLE.
  - Flush of an empty tag: FLUSH lasts one cycle with no slot movement, then IDLE.
  - push_rdy=0 and pop_rdy=0 throughout FLUSH.
  - flush_req in the same cycle as an accepted pop: the pop completes first and the flush starts the same cycle on the updated list.
- Counts:
  - free_cnt + sum(tag_cnt) == DEPTH at all times.
  - No counter wraps; overflow and underflow cannot occur under legal handshakes and are flagged by simulation assertions.
- Reset mid-operation: all state returns to reset values immediately, including during FLUSH. In-flight pop_vld is cleared.

Decomposition:
- apb2axi_pkg: RDF_DEPTH (default for DEPTH), and typedef rdf_slot_idx_t.
- Reused unchanged: rdf_entry_t, TAG_W, TAG_NUM.
- One natural sub-module: apb2axi_rdf_freelist. It is a DEPTH-entry index FIFO, reset-initialised to 0..DEPTH-1, with one alloc and one free port per cycle and a count output.

Test Plan:
- Reset → free_cnt=32, push_rdy=1, tag_done=0. Push 4 beats tag 2 (data 0xA0..0xA3, last on 4th) → tag_cnt[2]=4, tag_done[2]=1, free_cnt=28.
- Interleaved pushes tag1 0x10, tag3 0x30, tag1 0x11(last), tag3 0x31(last); pop tag 3 twice → pop_payload data 0x30 then 0x31, each one cycle after the request; tag_done[3]=0.
- Fill all 32 slots (tag 0) → push_rdy=0, free_cnt=0. Pop one beat → push_rdy=1 the next cycle. Push and pop the same cycle → free_cnt stays 1.
- Tag 5 holding 1 beat (0x50): same-cycle pop of tag 5 and push of tag 5 (0x51) → pop returns 0x50, tag_cnt[5]=1, next pop returns 0x51.
- Flush tag 4 holding 3 beats → flush_busy for 3 cycles, push_rdy=0 and pop_rdy=0 during the flush, then tag_cnt[4]=0, tag_done[4]=0, free_cnt restored. Flush of an empty tag → busy for 1 cycle.
- Assert aresetn mid-flush and mid-pop → all outputs return to reset values asynchronously. Post-reset pushes allocate slot 0 first.
